// File: rtl/audio_i2s_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : audio_i2s_tx
//  Description : I2S transmitter. A phase accumulator on clk_74a produces the
//                master clock edges; sclk = mclk/4 and 64 sclk periods form one
//                stereo frame of two 32-bit MSB-aligned slots. One stereo
//                sample is taken per frame from a holding register or, when
//                AUDIO_I2S_TX_FIFO_EN is defined, from a FIFO_DEPTH-entry FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_i2s_tx #(
    parameter int IN_WIDTH   = 16,
    parameter int ACC_WIDTH  = 21,
    parameter int PHASE_INC  = 694138,
    parameter int MONO       = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk_74a,
    input  logic                reset_n,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic [IN_WIDTH-1:0] sample_left,
    input  logic [IN_WIDTH-1:0] sample_right,
    output logic                audio_mclk,
    output logic                audio_lrck,
    output logic                audio_dac,
    output logic                frame_start,
    output logic                underrun
);

    localparam logic [ACC_WIDTH:0] c_INC = (ACC_WIDTH + 1)'(PHASE_INC);

    // Reject illegal configurations at elaboration time
    if (IN_WIDTH < 8 || IN_WIDTH > 32) begin : g_bad_in_width
        $error("audio_i2s_tx: IN_WIDTH must be within 8..32");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("audio_i2s_tx: FIFO_DEPTH must be a power of 2, at least 2");
    end

    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH:0]   w_acc_sum;
    logic                 w_mclk_edge;
    logic [1:0]           r_sclk_div;
    logic                 r_sclk;
    logic                 w_sclk_fall;
    logic [5:0]           r_bit_cnt;
    logic [5:0]           w_bit_cnt_nxt;
    logic                 w_frame_load;
    logic [63:0]          r_shift;
    logic [63:0]          r_last_frame;
    logic [63:0]          w_load_frame;
    logic                 r_ready_en;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_have_sample;
    logic [IN_WIDTH-1:0]  w_head_left;
    logic [IN_WIDTH-1:0]  w_head_right;

    // Place a sample MSB-first in a 32-bit slot, zero-padding the LSBs
    function automatic logic [31:0] to_slot(input logic [IN_WIDTH-1:0] s);
        logic [31:0] v;
        v = '0;
        v[31 -: IN_WIDTH] = s;
        return v;
    endfunction

    assign w_acc_sum     = {1'b0, r_acc} + c_INC;
    assign w_mclk_edge   = w_acc_sum[ACC_WIDTH];
    assign w_sclk_fall   = w_mclk_edge && (r_sclk_div == 2'd3) && r_sclk;
    assign w_bit_cnt_nxt = r_bit_cnt + 6'd1;
    assign w_frame_load  = w_sclk_fall && (r_bit_cnt == 6'd63);
    assign w_push        = sample_valid && sample_ready;
    assign w_pop         = w_frame_load && w_have_sample;

    // In mono mode the right input is never looked at
    always_comb begin
        w_load_frame = r_last_frame;
        if (w_have_sample) begin
            w_load_frame = {to_slot(w_head_left),
                            to_slot((MONO != 0) ? w_head_left : w_head_right)};
        end
    end

    // Phase accumulator, mclk toggle and the mclk/4 sclk divider
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_acc      <= '0;
            audio_mclk <= 1'b0;
            r_sclk_div <= 2'd0;
            r_sclk     <= 1'b0;
        end else begin
            r_acc <= w_acc_sum[ACC_WIDTH-1:0];
            if (w_mclk_edge) begin
                audio_mclk <= ~audio_mclk;
                r_sclk_div <= r_sclk_div + 2'd1;
                if (r_sclk_div == 2'd3) begin
                    r_sclk <= ~r_sclk;
                end
            end
        end
    end

    // Serializer: on each sclk fall advance the bit counter, shift data out
    // and, when the counter wraps, load the next frame (one-bit I2S delay
    // comes from emitting the old MSB before the load takes effect)
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt    <= 6'd0;
            audio_lrck   <= 1'b0;
            audio_dac    <= 1'b0;
            r_shift      <= '0;
            r_last_frame <= '0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            frame_start <= w_frame_load;
            underrun    <= w_frame_load && !w_have_sample;
            if (w_sclk_fall) begin
                r_bit_cnt  <= w_bit_cnt_nxt;
                audio_lrck <= w_bit_cnt_nxt[5];
                audio_dac  <= r_shift[63];
                if (w_frame_load) begin
                    r_shift      <= w_load_frame;
                    r_last_frame <= w_load_frame;
                end else begin
                    r_shift <= {r_shift[62:0], 1'b0};
                end
            end
        end
    end

    // Hold off acceptance until the first edge after reset release
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

`ifdef AUDIO_I2S_TX_FIFO_EN
    localparam int             c_AW    = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]  c_DEPTH = (c_AW + 1)'(FIFO_DEPTH);

    logic [IN_WIDTH-1:0] r_fifo_left  [FIFO_DEPTH];
    logic [IN_WIDTH-1:0] r_fifo_right [FIFO_DEPTH];
    logic [c_AW-1:0]     r_wr_ptr;
    logic [c_AW-1:0]     r_rd_ptr;
    logic [c_AW:0]       r_count;

    assign w_have_sample = (r_count != '0);
    assign sample_ready  = r_ready_en && (r_count != c_DEPTH);
    assign w_head_left   = r_fifo_left[r_rd_ptr];
    assign w_head_right  = r_fifo_right[r_rd_ptr];

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk_74a) begin
        if (w_push) begin
            r_fifo_left[r_wr_ptr]  <= sample_left;
            r_fifo_right[r_wr_ptr] <= sample_right;
        end
    end

    // FIFO pointers (natural power-of-2 wrap) and occupancy
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    logic                r_hold_full;
    logic [IN_WIDTH-1:0] r_hold_left;
    logic [IN_WIDTH-1:0] r_hold_right;

    assign w_have_sample = r_hold_full;
    assign sample_ready  = r_ready_en && !r_hold_full;
    assign w_head_left   = r_hold_left;
    assign w_head_right  = r_hold_right;

    // Holding register data; valid only while r_hold_full is set
    always_ff @(posedge clk_74a) begin
        if (w_push) begin
            r_hold_left  <= sample_left;
            r_hold_right <= sample_right;
        end
    end

    // Holding register occupancy; push needs empty and pop needs full,
    // so the two never coincide
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_full <= 1'b0;
        end else if (w_push) begin
            r_hold_full <= 1'b1;
        end else if (w_pop) begin
            r_hold_full <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire
